ex_mem_stage: RTL and testbench

- Parametrised EX/MEM pipeline register, successor to the basic GPR-only EX/MEM latch.
- Carries GPR writeback, HI/LO writeback, ALU op, memory address and store data from EX into MEM.
- Adds stall/flush control, a valid bit, and a feedback path that holds the multi-cycle accumulate state (madd/msub partial product, cycle count) while EX is stalled.
- Sits between ex and mem; driven by the stall controller (ctrl) and exception flush.

---
 rtl/ex_mem_stage_if.sv | 47 ++++
 rtl/ex_mem_stage.sv | 68 ++++++
 tb/tb_ex_mem_stage.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM pipeline bundle: the fields EX hands over plus the registered copies
// MEM sees and the accumulate feedback returned to EX.
interface ex_mem_stage_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8,
  parameter int CNT_W   = 2
);
  logic [ADDR_W-1:0]   ex_waddr;
  logic                ex_we;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [DATA_W-1:0]   ex_mem_addr;
  logic [DATA_W-1:0]   ex_reg2;
  logic [2*DATA_W-1:0] ex_hilo_temp;
  logic [CNT_W-1:0]    ex_cnt;

  logic [ADDR_W-1:0]   mem_waddr;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [ALUOP_W-1:0]  mem_aluop;
  logic [DATA_W-1:0]   mem_mem_addr;
  logic [DATA_W-1:0]   mem_reg2;
  logic                mem_valid;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [CNT_W-1:0]    cnt_o;

  modport master (
    output ex_waddr, ex_we, ex_wdata, ex_whilo, ex_hi, ex_lo,
           ex_aluop, ex_mem_addr, ex_reg2, ex_hilo_temp, ex_cnt,
    input  mem_waddr, mem_we, mem_wdata, mem_whilo, mem_hi, mem_lo,
           mem_aluop, mem_mem_addr, mem_reg2, mem_valid, hilo_temp_o, cnt_o
  );

  modport slave (
    input  ex_waddr, ex_we, ex_wdata, ex_whilo, ex_hi, ex_lo,
           ex_aluop, ex_mem_addr, ex_reg2, ex_hilo_temp, ex_cnt,
    output mem_waddr, mem_we, mem_wdata, mem_whilo, mem_hi, mem_lo,
           mem_aluop, mem_mem_addr, mem_reg2, mem_valid, hilo_temp_o, cnt_o
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush control, a valid bit, and a hold
// path for the madd/msub accumulate state while EX is stalled.
module ex_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8,
  parameter int CNT_W   = 2
) (
  input logic           clk,
  input logic           rst,
  input logic           stall_ex,
  input logic           stall_mem,
  input logic           flush,
  ex_mem_stage_if.slave bus
);

  // Flow control: no valid/ready pair here. mem_valid=1 means the MEM-side
  // fields hold a real instruction; stall_ex/stall_mem come from the stall
  // controller, and stall_mem may only be high while stall_ex is high.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      bus.mem_waddr    <= '0;
      bus.mem_we       <= 1'b0;
      bus.mem_wdata    <= '0;
      bus.mem_whilo    <= 1'b0;
      bus.mem_hi       <= '0;
      bus.mem_lo       <= '0;
      bus.mem_aluop    <= '0;
      bus.mem_mem_addr <= '0;
      bus.mem_reg2     <= '0;
      bus.mem_valid    <= 1'b0;
      bus.hilo_temp_o  <= '0;
      bus.cnt_o        <= '0;
    end else if (!stall_ex) begin
      bus.mem_waddr    <= bus.ex_waddr;
      bus.mem_we       <= bus.ex_we;
      bus.mem_wdata    <= bus.ex_wdata;
      bus.mem_whilo    <= bus.ex_whilo;
      bus.mem_hi       <= bus.ex_hi;
      bus.mem_lo       <= bus.ex_lo;
      bus.mem_aluop    <= bus.ex_aluop;
      bus.mem_mem_addr <= bus.ex_mem_addr;
      bus.mem_reg2     <= bus.ex_reg2;
      bus.mem_valid    <= 1'b1;
      bus.hilo_temp_o  <= '0;
      bus.cnt_o        <= '0;
    end else if (!stall_mem) begin
      // Bubble into MEM; park the partial product so EX can resume next cycle.
      bus.mem_waddr    <= '0;
      bus.mem_we       <= 1'b0;
      bus.mem_wdata    <= '0;
      bus.mem_whilo    <= 1'b0;
      bus.mem_hi       <= '0;
      bus.mem_lo       <= '0;
      bus.mem_aluop    <= '0;
      bus.mem_mem_addr <= '0;
      bus.mem_reg2     <= '0;
      bus.mem_valid    <= 1'b0;
      bus.hilo_temp_o  <= bus.ex_hilo_temp;
      bus.cnt_o        <= bus.ex_cnt;
    end
  end

  illegal_stall_combo : assert property (
    @(posedge clk) disable iff (rst) !(!stall_ex && stall_mem)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: one 32-bit and one 64-bit instance share stimulus and
// are scored against a rule-level reference model.
module tb_ex_mem_stage;

  typedef struct packed {
    logic         rst, stall_ex, stall_mem, flush;
    logic [5:0]   waddr;
    logic         we;
    logic [63:0]  wdata;
    logic         whilo;
    logic [63:0]  hi, lo;
    logic [7:0]   aluop;
    logic [63:0]  mem_addr, reg2;
    logic [127:0] hilo_temp;
    logic [1:0]   cnt;
  } stim_t;

  typedef struct packed {
    logic [5:0]   waddr;
    logic         we;
    logic [63:0]  wdata;
    logic         whilo;
    logic [63:0]  hi, lo;
    logic [7:0]   aluop;
    logic [63:0]  mem_addr, reg2;
    logic         valid;
    logic [127:0] hilo_temp;
    logic [1:0]   cnt;
  } out_t;

  localparam int OUT_W = $bits(out_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, stall_ex = 1'b0, stall_mem = 1'b0, flush = 1'b0;

  ex_mem_stage_if #(.DATA_W(32), .ADDR_W(5), .ALUOP_W(8), .CNT_W(2)) if32 ();
  ex_mem_stage_if #(.DATA_W(64), .ADDR_W(6), .ALUOP_W(8), .CNT_W(2)) if64 ();

  ex_mem_stage #(.DATA_W(32), .ADDR_W(5), .ALUOP_W(8), .CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush(flush), .bus(if32.slave)
  );

  ex_mem_stage #(.DATA_W(64), .ADDR_W(6), .ALUOP_W(8), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush(flush), .bus(if64.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [OUT_W-1:0] exp_q32[$];
  logic [OUT_W-1:0] exp_q64[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  out_t model = '0;

  // Reference: what MEM should see after one edge, stated by the pipeline rules.
  function automatic out_t model_step(out_t s, stim_t st);
    out_t n;
    n = s;
    if (st.rst || st.flush) begin
      n = '0;
    end else if (!st.stall_ex) begin
      n = '0;
      n.waddr = st.waddr;   n.we = st.we;       n.wdata = st.wdata;
      n.whilo = st.whilo;   n.hi = st.hi;       n.lo = st.lo;
      n.aluop = st.aluop;   n.mem_addr = st.mem_addr;
      n.reg2  = st.reg2;    n.valid = 1'b1;
    end else if (!st.stall_mem) begin
      n = '0;
      n.hilo_temp = st.hilo_temp;
      n.cnt       = st.cnt;
    end
    return n;
  endfunction

  function automatic out_t narrow(out_t e);
    out_t n;
    n = e;
    n.waddr[5]           = 1'b0;
    n.wdata[63:32]       = '0;
    n.hi[63:32]          = '0;
    n.lo[63:32]          = '0;
    n.mem_addr[63:32]    = '0;
    n.reg2[63:32]        = '0;
    n.hilo_temp[127:64]  = '0;
    return n;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic stim_t rand_fields();
    stim_t st;
    st = '0;
    st.waddr     = 6'($urandom_range(0, 63));
    st.we        = 1'($urandom_range(0, 1));
    st.wdata     = r64();
    st.whilo     = 1'($urandom_range(0, 1));
    st.hi        = r64();
    st.lo        = r64();
    st.aluop     = 8'($urandom_range(0, 255));
    st.mem_addr  = r64();
    st.reg2      = r64();
    st.hilo_temp = {r64(), r64()};
    st.cnt       = 2'($urandom_range(0, 3));
    return st;
  endfunction

  function automatic stim_t rand_stim();
    stim_t st;
    int r;
    st = rand_fields();
    r = $urandom_range(0, 9);
    st.stall_ex  = (r >= 5);
    st.stall_mem = (r >= 7);
    st.flush     = ($urandom_range(0, 24) == 0);
    st.rst       = ($urandom_range(0, 49) == 0);
    return st;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input stim_t st);
    @(negedge clk);
    rst = st.rst;  stall_ex = st.stall_ex;  stall_mem = st.stall_mem;  flush = st.flush;
    if32.ex_waddr     = st.waddr[4:0];      if64.ex_waddr     = st.waddr;
    if32.ex_we        = st.we;              if64.ex_we        = st.we;
    if32.ex_wdata     = st.wdata[31:0];     if64.ex_wdata     = st.wdata;
    if32.ex_whilo     = st.whilo;           if64.ex_whilo     = st.whilo;
    if32.ex_hi        = st.hi[31:0];        if64.ex_hi        = st.hi;
    if32.ex_lo        = st.lo[31:0];        if64.ex_lo        = st.lo;
    if32.ex_aluop     = st.aluop;           if64.ex_aluop     = st.aluop;
    if32.ex_mem_addr  = st.mem_addr[31:0];  if64.ex_mem_addr  = st.mem_addr;
    if32.ex_reg2      = st.reg2[31:0];      if64.ex_reg2      = st.reg2;
    if32.ex_hilo_temp = st.hilo_temp[63:0]; if64.ex_hilo_temp = st.hilo_temp;
    if32.ex_cnt       = st.cnt;             if64.ex_cnt       = st.cnt;
    model = model_step(model, st);
    exp_q64.push_back(model);
    exp_q32.push_back(narrow(model));
  endtask

  // ---------------- monitor ----------------
  function automatic out_t act32();
    out_t a;
    a.waddr     = {1'b0, if32.mem_waddr};
    a.we        = if32.mem_we;
    a.wdata     = {32'b0, if32.mem_wdata};
    a.whilo     = if32.mem_whilo;
    a.hi        = {32'b0, if32.mem_hi};
    a.lo        = {32'b0, if32.mem_lo};
    a.aluop     = if32.mem_aluop;
    a.mem_addr  = {32'b0, if32.mem_mem_addr};
    a.reg2      = {32'b0, if32.mem_reg2};
    a.valid     = if32.mem_valid;
    a.hilo_temp = {64'b0, if32.hilo_temp_o};
    a.cnt       = if32.cnt_o;
    return a;
  endfunction

  function automatic out_t act64();
    out_t a;
    a.waddr     = if64.mem_waddr;
    a.we        = if64.mem_we;
    a.wdata     = if64.mem_wdata;
    a.whilo     = if64.mem_whilo;
    a.hi        = if64.mem_hi;
    a.lo        = if64.mem_lo;
    a.aluop     = if64.mem_aluop;
    a.mem_addr  = if64.mem_mem_addr;
    a.reg2      = if64.mem_reg2;
    a.valid     = if64.mem_valid;
    a.hilo_temp = if64.hilo_temp_o;
    a.cnt       = if64.cnt_o;
    return a;
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] e);
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %h required %h", name, cyc, a, e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q32.size() > 0) check("dut32", act32(), exp_q32.pop_front());
      if (exp_q64.size() > 0) check("dut64", act64(), exp_q64.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t st;
    int    wait_cycles;

    // Reset with random inputs, then first advance.
    for (int i = 0; i < 3; i++) begin
      st = rand_stim();
      st.rst = 1'b1;
      drive(st);
    end
    st = rand_fields();
    st.waddr = 6'd3;  st.we = 1'b1;  st.wdata = 64'hFEDC_BA98_1234_5678;
    drive(st);

    // Bubble carrying accumulate state, then resume.
    st = rand_fields();
    st.stall_ex = 1'b1;  st.we = 1'b1;  st.cnt = 2'd1;
    st.hilo_temp = 128'hFFFF_0000_1234_5678_0000_0001_FFFF_FFFE;
    drive(st);
    drive(rand_fields());

    // Load HI then hold four cycles under changing inputs.
    st = rand_fields();
    st.hi = 64'h5555_0000_AAAA_0000;  st.whilo = 1'b1;
    drive(st);
    for (int i = 0; i < 4; i++) begin
      st = rand_fields();
      st.stall_ex = 1'b1;  st.stall_mem = 1'b1;
      drive(st);
    end

    // Flush while held, once over valid contents and once over parked accumulate.
    st = rand_fields();
    st.stall_ex = 1'b1;  st.stall_mem = 1'b1;  st.flush = 1'b1;
    drive(st);
    st = rand_fields();
    st.stall_ex = 1'b1;  st.cnt = 2'd3;
    drive(st);
    st = rand_fields();
    st.stall_ex = 1'b1;  st.stall_mem = 1'b1;
    drive(st);
    st.flush = 1'b1;
    drive(st);

    // Load/store fields.
    st = rand_fields();
    st.aluop = 8'hE3;  st.mem_addr = 64'h0000_0000_0000_0100;
    st.reg2 = 64'h0123_4567_DEAD_BEEF;
    drive(st);

    for (int i = 0; i < 400; i++) drive(rand_stim());

    wait_cycles = 0;
    while ((exp_q32.size() > 0 || exp_q64.size() > 0) && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q32.size() > 0 || exp_q64.size() > 0) begin
      tests_failed++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", exp_q32.size(), exp_q64.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
